// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from vga_timing_gen to the renderer and RGB stage
interface vga_timing_gen_if;
    logic       pix_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_end;
    logic       frame_start;

    // Timing generator drives the bundle
    modport master (
        output pix_tick,
        output hsync,
        output vsync,
        output video_on,
        output x,
        output y,
        output line_end,
        output frame_start
    );

    // Renderer / RGB register consume it
    modport slave (
        input pix_tick,
        input hsync,
        input vsync,
        input video_on,
        input x,
        input y,
        input line_end,
        input frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster timing driven by a rising-edge-detected pixel clock level
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pclk,
    vga_timing_gen_if.master  vif
);
    // Totals must stay within the 10-bit counters (<= 1024)
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] L_H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] L_V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] L_H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] L_V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] L_HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] L_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] L_VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] L_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       r_pclk_q;
    logic       r_pix_tick;
    logic [9:0] r_h;
    logic [9:0] r_v;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic       r_line_end;
    logic       r_frame_start;

    logic       w_tick;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       w_hs_on;
    logic       w_vs_on;
    logic       w_vid;

    // Next counter values and their decodes; outputs are registered from
    // these so sync/video always line up with x/y in the same cycle
    always_comb begin
        w_tick   = pclk & ~r_pclk_q;
        w_h_wrap = (r_h == L_H_LAST);
        w_v_wrap = w_h_wrap && (r_v == L_V_LAST);
        w_h_next = w_h_wrap ? 10'd0 : r_h + 10'd1;
        w_v_next = r_v;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? 10'd0 : r_v + 10'd1;
        end
        w_hs_on  = (w_h_next >= L_HS_START) && (w_h_next < L_HS_END);
        w_vs_on  = (w_v_next >= L_VS_START) && (w_v_next < L_VS_END);
        w_vid    = (w_h_next < L_H_ACT) && (w_v_next < L_V_ACT);
    end

    // Edge detector; pclk_q resets high so a pclk already high at release is not a tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pclk_q   <= 1'b1;
            r_pix_tick <= 1'b0;
        end else begin
            r_pclk_q   <= pclk;
            r_pix_tick <= w_tick;
        end
    end

    // Raster counters, decoded outputs and strobes advance only on a tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h           <= 10'd0;
            r_v           <= 10'd0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_tick) begin
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_hsync       <= w_hs_on ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= w_vid;
            r_line_end    <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end else begin
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign vif.pix_tick    = r_pix_tick;
    assign vif.hsync       = r_hsync;
    assign vif.vsync       = r_vsync;
    assign vif.video_on    = r_video_on;
    assign vif.x           = r_h;
    assign vif.y           = r_v;
    assign vif.line_end    = r_line_end;
    assign vif.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen at full size and a reduced raster
module tb_vga_timing_gen;
    logic clk;
    logic rst_n;
    logic pclk;
    logic hold;

    int vectors;
    int miscompares;

    // Reference raster positions for the full-size (m) and reduced (s) instances
    int ex, ey, sx, sy;
    int n_ticks;
    int m_hs_n, m_le_n, m_vid_n;
    int s_hs_n, s_vs_n, s_le_n, s_vid_n, s_fs_n;

    vga_timing_gen_if mif();
    vga_timing_gen_if sif();

    vga_timing_gen u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .pclk  (pclk),
        .vif   (mif.master)
    );

    // Reduced raster: H 4+2+3+1 = 10, V 3+1+2+1 = 7, active-high sync
    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (2), .H_SYNC (3), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL (1'b1)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .pclk  (pclk),
        .vif   (sif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider N=4: pclk toggles every 2 clk on the falling edge; hold parks it high
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (!hold || !pclk) begin
                ph++;
                if (ph == 2) begin
                    ph = 0;
                    pclk = ~pclk;
                end
            end
        end
    end

    function automatic logic [24:0] m_bundle();
        return {mif.x, mif.y, mif.hsync, mif.vsync, mif.video_on, mif.line_end, mif.frame_start};
    endfunction

    function automatic logic [24:0] s_bundle();
        return {sif.x, sif.y, sif.hsync, sif.vsync, sif.video_on, sif.line_end, sif.frame_start};
    endfunction

    task automatic clear_model();
        ex = 0; ey = 0; sx = 0; sy = 0; n_ticks = 0;
        m_hs_n = 0; m_le_n = 0; m_vid_n = 0;
        s_hs_n = 0; s_vs_n = 0; s_le_n = 0; s_vid_n = 0; s_fs_n = 0;
    endtask

    // Wait (bounded) for the next pix_tick, advance the reference raster, compare both instances
    task automatic check_tick(output int waited);
        logic got;
        logic m_le, m_fs, s_le, s_fs;
        logic [24:0] m_exp, s_exp;
        got = 1'b0;
        waited = 0;
        while (!got && waited < 20) begin
            @(posedge clk); #1;
            waited++;
            if (mif.pix_tick) got = 1'b1;
        end
        n_ticks++;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL tick_timeout: pix_tick not seen in %0d clk, required within 20", waited);
        end else begin
            m_le = (ex == 799);
            ex   = m_le ? 0 : ex + 1;
            if (m_le) ey = (ey == 524) ? 0 : ey + 1;
            m_fs = (ex == 0) && (ey == 0);
            m_exp = {10'(ex), 10'(ey),
                     !(ex >= 656 && ex < 752), !(ey >= 490 && ey < 492),
                     (ex < 640 && ey < 480), m_le, m_fs};
            s_le = (sx == 9);
            sx   = s_le ? 0 : sx + 1;
            if (s_le) sy = (sy == 6) ? 0 : sy + 1;
            s_fs = (sx == 0) && (sy == 0);
            s_exp = {10'(sx), 10'(sy),
                     (sx >= 6 && sx < 9), (sy >= 4 && sy < 6),
                     (sx < 4 && sy < 3), s_le, s_fs};
            if (m_bundle() !== m_exp) begin
                miscompares++;
                $display("FAIL main_tick: {x,y,hs,vs,vid,le,fs} got %h required %h", m_bundle(), m_exp);
            end
            vectors++;
            if (s_bundle() !== s_exp) begin
                miscompares++;
                $display("FAIL small_tick: {x,y,hs,vs,vid,le,fs} got %h required %h", s_bundle(), s_exp);
            end
            if (!mif.hsync)      m_hs_n++;
            if (mif.line_end)    m_le_n++;
            if (mif.video_on)    m_vid_n++;
            if (sif.hsync)       s_hs_n++;
            if (sif.vsync)       s_vs_n++;
            if (sif.line_end)    s_le_n++;
            if (sif.video_on)    s_vid_n++;
            if (sif.frame_start) s_fs_n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pclk  = 1'b1;
        hold  = 1'b1;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({mif.pix_tick, m_bundle()} !== {1'b0, 10'd0, 10'd0, 5'b11000}) begin
            miscompares++;
            $display("FAIL reset_main: got %h required %h", {mif.pix_tick, m_bundle()}, {1'b0, 10'd0, 10'd0, 5'b11000});
        end
        vectors++;
        if ({sif.pix_tick, s_bundle()} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_small: got %h required 0", {sif.pix_tick, s_bundle()});
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        // pclk is already high at release: no tick may appear
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (mif.pix_tick !== 1'b0 || mif.x !== 10'd0) begin
                miscompares++;
                $display("FAIL no_false_tick: cycle %0d pix_tick=%b x=%0d required 0,0", i, mif.pix_tick, mif.x);
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_tick_rate();
        int w;
        check_tick(w);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (mif.pix_tick !== 1'b0) begin
                miscompares++;
                $display("FAIL tick_width: pix_tick=%b one clk after tick, required 0", mif.pix_tick);
            end
            check_tick(w);
            vectors++;
            if (w != 3) begin
                miscompares++;
                $display("FAIL tick_period: %0d clk after width check, required 3 (period 4)", w);
            end
        end
        vectors++;
        if (mif.x !== 10'd6) begin
            miscompares++;
            $display("FAIL tick_count: x=%0d after 6 ticks, required 6", mif.x);
        end
    endtask

    task automatic test_frame();
        int w;
        for (int i = n_ticks; i < 70; i++) begin
            check_tick(w);
            if (sx == 3 && sy == 2) begin
                vectors++;
                if (sif.video_on !== 1'b1) begin
                    miscompares++;
                    $display("FAIL vid_last_active: video_on=%b at (3,2) required 1", sif.video_on);
                end
            end
            if (sx == 4 && sy == 2) begin
                vectors++;
                if (sif.video_on !== 1'b0) begin
                    miscompares++;
                    $display("FAIL vid_h_edge: video_on=%b at (4,2) required 0", sif.video_on);
                end
            end
            if (sx == 0 && sy == 3) begin
                vectors++;
                if (sif.video_on !== 1'b0) begin
                    miscompares++;
                    $display("FAIL vid_v_edge: video_on=%b at (0,3) required 0", sif.video_on);
                end
            end
        end
        vectors++;
        if ({sif.x, sif.y, sif.line_end, sif.frame_start} !== {10'd0, 10'd0, 2'b11}) begin
            miscompares++;
            $display("FAIL frame_wrap: x=%0d y=%0d le=%b fs=%b required 0 0 1 1", sif.x, sif.y, sif.line_end, sif.frame_start);
        end
        vectors++;
        if ({s_fs_n, s_le_n, s_vid_n, s_vs_n, s_hs_n} !== {32'd1, 32'd7, 32'd12, 32'd20, 32'd21}) begin
            miscompares++;
            $display("FAIL frame_counts: fs=%0d le=%0d vid=%0d vs=%0d hs=%0d required 1 7 12 20 21", s_fs_n, s_le_n, s_vid_n, s_vs_n, s_hs_n);
        end
    endtask

    task automatic test_full_line();
        int w;
        repeat (730) check_tick(w);
        vectors++;
        if (mif.x !== 10'd0 || mif.y !== 10'd1 || mif.line_end !== 1'b1 || mif.frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL line0_end: x=%0d y=%0d le=%b fs=%b required 0 1 1 0", mif.x, mif.y, mif.line_end, mif.frame_start);
        end
        m_hs_n = 0; m_le_n = 0; m_vid_n = 0;
        repeat (800) check_tick(w);
        vectors++;
        if ({m_hs_n, m_le_n, m_vid_n} !== {32'd96, 32'd1, 32'd640}) begin
            miscompares++;
            $display("FAIL line_counts: hs_low=%0d le=%0d vid=%0d required 96 1 640", m_hs_n, m_le_n, m_vid_n);
        end
        vectors++;
        if (mif.x !== 10'd0 || mif.y !== 10'd2) begin
            miscompares++;
            $display("FAIL line1_end: x=%0d y=%0d required 0 2", mif.x, mif.y);
        end
    endtask

    task automatic test_hold();
        int w;
        logic [25:0] m_snap, s_snap;
        repeat (150) check_tick(w);
        hold = 1'b1;
        @(posedge clk); #1;
        m_snap = {mif.pix_tick, m_bundle()};
        s_snap = {sif.pix_tick, s_bundle()};
        vectors++;
        if (m_snap !== {1'b0, 10'd150, 10'd2, 5'b11100}) begin
            miscompares++;
            $display("FAIL hold_entry: got %h required %h", m_snap, {1'b0, 10'd150, 10'd2, 5'b11100});
        end
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({mif.pix_tick, m_bundle()} !== m_snap || {sif.pix_tick, s_bundle()} !== s_snap) begin
                miscompares++;
                $display("FAIL hold_freeze: cycle %0d main %h small %h required %h %h", i, {mif.pix_tick, m_bundle()}, {sif.pix_tick, s_bundle()}, m_snap, s_snap);
            end
        end
        hold = 1'b0;
        check_tick(w);
        vectors++;
        if (mif.x !== 10'd151) begin
            miscompares++;
            $display("FAIL hold_resume: x=%0d required 151", mif.x);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({mif.pix_tick, m_bundle()} !== {1'b0, 10'd0, 10'd0, 5'b11000}) begin
            miscompares++;
            $display("FAIL reset_async: got %h required %h", {mif.pix_tick, m_bundle()}, {1'b0, 10'd0, 10'd0, 5'b11000});
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({mif.pix_tick, m_bundle()} !== {1'b0, 10'd0, 10'd0, 5'b11000} || {sif.pix_tick, s_bundle()} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_held: main %h small %h required %h 0", {mif.pix_tick, m_bundle()}, {sif.pix_tick, s_bundle()}, {1'b0, 10'd0, 10'd0, 5'b11000});
        end
        #1;
        rst_n = 1'b1;
        clear_model();
        check_tick(w);
        vectors++;
        if (mif.x !== 10'd1 || mif.y !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_restart: x=%0d y=%0d required 1 0", mif.x, mif.y);
        end
        repeat (3) check_tick(w);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_tick_rate();
        test_frame();
        test_full_line();
        test_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
